// File: rtl/proc_datapath.sv
// Execution datapath: 16-entry register file, immediate/operand/read-latch/result
// registers and an 8-op ALU, driven by per-cycle control strobes from the controller.
module proc_datapath #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_imm,
   input  logic [DW-1:0] imm,
   input  logic          sel_mux,
   input  logic          en_reg,
   input  logic          en_rf,
   input  logic          r_wf,
   input  logic [3:0]    sel_rf,
   input  logic          en_alu,
   input  logic [2:0]    sel_alu,
   output logic          alu_zero,
   output logic [DW-1:0] ram_wdata,
   input  logic [3:0]    dbg_sel,
   output logic [DW-1:0] dbg_data
);

   logic [DW-1:0] rf [16];
   logic [DW-1:0] imm_r;
   logic [DW-1:0] a_r;
   logic [DW-1:0] rd_r;
   logic [DW-1:0] res_r;
   logic          z_r;

   logic [DW-1:0] b_op;
   logic [DW-1:0] alu_res;
   logic [31:0]   sh_amt;
   logic          res_zero;

   assign b_op   = sel_mux ? rd_r : imm_r;
   assign sh_amt = {28'd0, a_r[3:0]};

   always_comb begin
      alu_res = '0;
      unique case (sel_alu)
         3'b000:  alu_res = b_op;
         3'b001:  alu_res = b_op;
         3'b010:  alu_res = a_r + b_op;
         3'b011:  alu_res = b_op - a_r;
         3'b100:  alu_res = (sh_amt >= DW) ? '0 : (b_op << sh_amt);
         3'b101:  alu_res = (sh_amt >= DW) ? '0 : (b_op >> sh_amt);
         3'b110:  alu_res = a_r & b_op;
         3'b111:  alu_res = a_r | b_op;
         default: alu_res = '0;
      endcase
   end

   assign res_zero = (alu_res == '0);

   // Flag is live during the ALU strobe so a jump decision needs no extra cycle.
   assign alu_zero  = en_alu ? res_zero : z_r;
   assign ram_wdata = res_r;
   assign dbg_data  = rf[dbg_sel];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) rf[i] <= '0;
         imm_r <= '0;
         a_r   <= '0;
         rd_r  <= '0;
         res_r <= '0;
         z_r   <= 1'b0;
      end else begin
         if (en_imm) imm_r <= imm;
         if (en_reg) a_r <= b_op;
         if (en_alu) begin
            res_r <= alu_res;
            z_r   <= res_zero;
         end
         // Write uses the pre-edge res_r, so a coincident ALU op is not forwarded.
         if (en_rf) begin
            if (r_wf) rd_r <= rf[sel_rf];
            else      rf[sel_rf] <= res_r;
         end
      end
   end

endmodule

// File: tb/tb_proc_datapath.sv
// Directed bench for proc_datapath: micro-sequence tasks, hand-computed expectations.
module tb_proc_datapath;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en_imm;
   logic [DW-1:0] imm;
   logic          sel_mux;
   logic          en_reg;
   logic          en_rf;
   logic          r_wf;
   logic [3:0]    sel_rf;
   logic          en_alu;
   logic [2:0]    sel_alu;
   logic          alu_zero;
   logic [DW-1:0] ram_wdata;
   logic [3:0]    dbg_sel;
   logic [DW-1:0] dbg_data;

   int n_checks = 0;
   int n_pass   = 0;
   logic z_seen;

   proc_datapath #(.DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .en_imm(en_imm), .imm(imm), .sel_mux(sel_mux),
      .en_reg(en_reg), .en_rf(en_rf), .r_wf(r_wf), .sel_rf(sel_rf),
      .en_alu(en_alu), .sel_alu(sel_alu), .alu_zero(alu_zero),
      .ram_wdata(ram_wdata), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic idle();
      en_imm = 0; en_reg = 0; en_rf = 0; en_alu = 0;
      r_wf = 0; sel_mux = 0; sel_rf = 0; sel_alu = 0; imm = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
      idle();
   endtask

   task automatic load_imm(input logic [DW-1:0] v);
      en_imm = 1; imm = v; step();
   endtask

   task automatic alu(input logic [2:0] op, input logic mux, output logic z);
      en_alu = 1; sel_alu = op; sel_mux = mux;
      #1 z = alu_zero;
      step();
   endtask

   task automatic rf_read(input logic [3:0] r);
      en_rf = 1; r_wf = 1; sel_rf = r; step();
   endtask

   task automatic rf_write(input logic [3:0] r);
      en_rf = 1; r_wf = 0; sel_rf = r; step();
   endtask

   task automatic reg_load(input logic mux);
      en_reg = 1; sel_mux = mux; step();
   endtask

   task automatic load_reg(input logic [3:0] r, input logic [DW-1:0] v);
      logic z;
      load_imm(v); alu(3'b000, 1'b0, z); rf_write(r);
   endtask

   // dst <- dst op src
   task automatic arith(input logic [3:0] src, input logic [3:0] dst, input logic [2:0] op,
                        output logic z);
      rf_read(src); reg_load(1'b1); rf_read(dst); alu(op, 1'b1, z); rf_write(dst);
   endtask

   task automatic shl(input logic [3:0] dst, input logic [DW-1:0] sh);
      logic z;
      load_imm(sh); reg_load(1'b0); rf_read(dst); alu(3'b100, 1'b1, z); rf_write(dst);
   endtask

   task automatic expect_reg(input string tag, input logic [3:0] r, input logic [DW-1:0] v);
      dbg_sel = r; #1;
      check(tag, 32'(dbg_data), 32'(v));
   endtask

   initial begin
      idle();
      dbg_sel = 0;
      rst_n = 0;
      #12;
      for (int i = 0; i < 16; i++) begin
         dbg_sel = 4'(i); #1;
         check($sformatf("rst_rf%0d", i), 32'(dbg_data), 32'h0);
      end
      check("rst_wdata", 32'(ram_wdata), 32'h0);
      check("rst_zero", 32'(alu_zero), 32'h0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      // Async reset wipes a freshly loaded register immediately
      load_reg(4'd3, 8'h77);
      expect_reg("r3_loaded", 4'd3, 8'h77);
      #2 rst_n = 0;
      #1 expect_reg("r3_async_rst", 4'd3, 8'h00);
      check("async_rst_wdata", 32'(ram_wdata), 32'h0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      // Load-immediate then add with carry drop
      load_reg(4'd1, 8'h05);
      load_reg(4'd2, 8'hFE);
      expect_reg("r1_li", 4'd1, 8'h05);
      expect_reg("r2_li", 4'd2, 8'hFE);
      arith(4'd1, 4'd2, 3'b010, z_seen);
      check("add_zero", 32'(z_seen), 32'h0);
      expect_reg("add_r2", 4'd2, 8'h03);

      // Sub to zero, then jump-if-zero tests
      load_reg(4'd4, 8'h10);
      load_reg(4'd5, 8'h10);
      arith(4'd4, 4'd5, 3'b011, z_seen);
      check("sub_zero", 32'(z_seen), 32'h1);
      expect_reg("sub_r5", 4'd5, 8'h00);
      load_reg(4'd9, 8'h33);
      rf_read(4'd5); alu(3'b001, 1'b1, z_seen);
      check("jz_r5_live", 32'(z_seen), 32'h1);
      step(); step();
      check("jz_r5_held", 32'(alu_zero), 32'h1);
      rf_read(4'd1); alu(3'b001, 1'b1, z_seen);
      check("jz_r1_live", 32'(z_seen), 32'h0);
      check("jz_r1_held", 32'(alu_zero), 32'h0);

      // Shift-left, including out-of-range amount
      load_reg(4'd6, 8'h81);
      shl(4'd6, 8'd1);
      expect_reg("shl1", 4'd6, 8'h02);
      load_reg(4'd6, 8'h81);
      shl(4'd6, 8'd8);
      expect_reg("shl8", 4'd6, 8'h00);
      load_reg(4'd6, 8'h11);
      shl(4'd6, 8'd3);
      expect_reg("shl3", 4'd6, 8'h88);

      // Store and move
      load_reg(4'd7, 8'hA5);
      load_imm(8'h00);
      rf_read(4'd7); alu(3'b000, 1'b1, z_seen);
      check("store_wdata", 32'(ram_wdata), 32'hA5);
      rf_write(4'd0);
      expect_reg("move_r0", 4'd0, 8'hA5);

      // Write coinciding with ALU stores the old result
      load_imm(8'h3C);
      en_rf = 1; r_wf = 0; sel_rf = 4'd8; en_alu = 1; sel_alu = 3'b000; sel_mux = 0;
      step();
      expect_reg("simul_r8", 4'd8, 8'hA5);
      check("simul_wdata", 32'(ram_wdata), 32'h3C);

      // en_reg coinciding with a read loads the old latch value (0x03)
      rf_read(4'd2);
      en_rf = 1; r_wf = 1; sel_rf = 4'd1; en_reg = 1; sel_mux = 1;
      step();
      alu(3'b010, 1'b1, z_seen);
      check("simul_areg_add", 32'(ram_wdata), 32'h08);
      alu(3'b110, 1'b1, z_seen);
      check("and_op", 32'(ram_wdata), 32'h01);
      alu(3'b111, 1'b1, z_seen);
      check("or_op", 32'(ram_wdata), 32'h07);
      alu(3'b101, 1'b1, z_seen);
      check("shr_op", 32'(ram_wdata), 32'h00);
      check("shr_zero", 32'(z_seen), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
